// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 width codes,
// FSM state encoding and small decode helpers used by mem_stage.
package mem_stage_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RET  = 2'd3
    } state_t;

    // Encodings that must never reach the memory port.
    function automatic logic mem_illegal(input logic rd_op, input logic wr_op,
                                         input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        if (rd_op && wr_op)
            bad = 1'b1;
        else if (rd_op)
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        else if (wr_op)
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return bad;
    endfunction

    // Half accesses need addr[0] clear, word accesses need addr[1:0] clear.
    function automatic logic mem_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = a[0];
            F3_W:        mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Low address bits with the offending bits dropped for the access width.
    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] a);
        logic [1:0] lo;
        case (f3)
            F3_H, F3_HU: lo = {a[1], 1'b0};
            F3_W:        lo = 2'b00;
            default:     lo = a;
        endcase
        return lo;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: builds byte enables and
// replicated store data, and extracts/extends the addressed load lane.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: enable the addressed lanes and replicate data across all lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between EXE and writeback. ALU results retire in one
// cycle; loads/stores run a req/gnt/rvalid handshake and stall EXE meanwhile.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// retire immediately with mem_exc instead of being silently aligned.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              mem_exc,
    output logic [XLEN-1:0]   mem_exc_addr
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              is_store_q, is_store_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              ex_fire, ex_is_mem, ex_bad, ex_mis;
    logic [3:0]        lane_be;
    logic [XLEN-1:0]   lane_wdata, lane_load;

    assign ex_fire   = ex_valid && ex_ready;
    assign ex_is_mem = ex_mem_read || ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic              mem_exc_q, mem_exc_d;
    logic [XLEN-1:0]   mem_exc_addr_q, mem_exc_addr_d;
    assign ex_mis       = !mem_illegal(ex_mem_read, ex_mem_write, ex_funct3) &&
                          mem_misaligned(ex_funct3, ex_alu_result[1:0]);
    assign mem_exc      = mem_exc_q;
    assign mem_exc_addr = mem_exc_addr_q;
`else
    assign ex_mis       = 1'b0;
    assign mem_exc      = 1'b0;
    assign mem_exc_addr = '0;
`endif

    assign ex_bad = mem_illegal(ex_mem_read, ex_mem_write, ex_funct3) || ex_mis;

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: only legal, aligned memory ops leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ex_fire && ex_is_mem && !ex_bad) state_d = ST_REQ;
            ST_REQ:  if (dmem_gnt) state_d = is_store_q ? ST_RET : ST_WAIT;
            ST_WAIT: if (dmem_rvalid) state_d = ST_RET;
            ST_RET:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Port outputs decoded from state; lanes are quiet outside REQ.
    always_comb begin
        ex_ready   = (state_q == ST_IDLE);
        dmem_req   = (state_q == ST_REQ);
        dmem_we    = dmem_req && is_store_q;
        dmem_be    = dmem_req ? lane_be : 4'b0000;
        dmem_wdata = dmem_req ? lane_wdata : '0;
    end

    assign dmem_addr    = {addr_q[XLEN-1:2], 2'b00};
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

    // Access latches and the retire record.
    always_comb begin
        addr_d         = addr_q;
        sdata_d        = sdata_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        is_store_d     = is_store_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
        mem_exc_d      = 1'b0;
        mem_exc_addr_d = mem_exc_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ex_fire) begin
                    if (ex_is_mem && !ex_bad) begin
                        addr_d      = {ex_alu_result[XLEN-1:2],
                                       align_lo(ex_funct3, ex_alu_result[1:0])};
                        sdata_d     = ex_store_data;
                        funct3_d    = ex_funct3;
                        rd_d        = ex_rd;
                        reg_write_d = ex_reg_write;
                        is_store_d  = ex_mem_write;
                    end else begin
                        // ALU result, or a memory op that is dropped without access.
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex_reg_write && !ex_is_mem;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
                        if (ex_mis) begin
                            mem_exc_d      = 1'b1;
                            mem_exc_addr_d = ex_alu_result;
                        end
`endif
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt && is_store_q) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_rd_d        = rd_q;
                    wb_data_d      = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = reg_write_q;
                    wb_rd_d        = rd_q;
                    wb_data_d      = lane_load;
                end
            end
            default: ;
        endcase
    end

    // Datapath and retire registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            sdata_q        <= '0;
            funct3_q       <= 3'b000;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            is_store_q     <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_exc_q      <= 1'b0;
            mem_exc_addr_q <= '0;
`endif
        end else begin
            addr_q         <= addr_d;
            sdata_q        <= sdata_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            is_store_q     <= is_store_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_exc_q      <= mem_exc_d;
            mem_exc_addr_q <= mem_exc_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads, illegal
// encodings, reset mid-access and misaligned word access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_exc;
    logic [31:0] mem_exc_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_exc       (mem_exc),
        .mem_exc_addr  (mem_exc_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle, then scramble ex_* inputs.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd_op,
                         input logic wr_op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw);
        ex_valid      = 1'b1;
        ex_alu_result = a;
        ex_store_data = d;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_reg_write  = rw;
        check("issue_ready", ex_ready, 1);
        tick;
        ex_valid      = 1'b0;
        ex_alu_result = 32'hBAD0BAD0;
        ex_store_data = 32'h5555AAAA;
        ex_funct3     = 3'b111;
        ex_rd         = 5'd31;
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input int gnt_delay);
        issue(a, d, 1'b0, 1'b1, f3, 5'd3, 1'b1);
        for (int i = 0; i <= gnt_delay; i++) begin
            check({tag, "_req"}, dmem_req, 1);
            check({tag, "_we"}, dmem_we, 1);
            check({tag, "_addr"}, dmem_addr, exp_addr);
            check({tag, "_be"}, dmem_be, exp_be);
            check({tag, "_wdata"}, dmem_wdata, exp_wdata);
            check({tag, "_stall"}, ex_ready, 0);
            check({tag, "_nowb"}, wb_valid, 0);
            if (i < gnt_delay) tick;
        end
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_wbrw"}, wb_reg_write, 0);
        check({tag, "_req_drop"}, dmem_req, 0);
        tick;
        check({tag, "_wb_pulse"}, wb_valid, 0);
        check({tag, "_ready_back"}, ex_ready, 1);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rdata, input int rv_delay,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        issue(a, 32'h0, 1'b1, 1'b0, f3, 5'd12, 1'b1);
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_we"}, dmem_we, 0);
        check({tag, "_addr"}, dmem_addr, exp_addr);
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        check({tag, "_wait_req"}, dmem_req, 0);
        check({tag, "_wait_stall"}, ex_ready, 0);
        for (int i = 1; i < rv_delay; i++) begin
            tick;
            check({tag, "_wait_nowb"}, wb_valid, 0);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_rd"}, wb_rd, 12);
        check({tag, "_wbrw"}, wb_reg_write, 1);
        tick;
        check({tag, "_wb_pulse"}, wb_valid, 0);
        check({tag, "_ready_back"}, ex_ready, 1);
    endtask

    logic [31:0] alu_vals [3] = '{32'h00000001, 32'hF0000000, 32'h00000000};

    initial begin
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_alu_result = 32'h0;
        ex_store_data = 32'h0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'h0;
        tick;
        tick;
        check("rst_ready", ex_ready, 1);
        check("rst_req", dmem_req, 0);
        check("rst_be", dmem_be, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_exc", mem_exc, 0);
        rst_n = 1'b1;
        tick;

        // Back-to-back ALU ops retire one per cycle.
        for (int i = 0; i < 3; i++) begin
            ex_valid      = 1'b1;
            ex_mem_read   = 1'b0;
            ex_mem_write  = 1'b0;
            ex_alu_result = alu_vals[i];
            ex_rd         = 5'(5 + i);
            ex_reg_write  = 1'b1;
            check("alu_ready", ex_ready, 1);
            tick;
            check("alu_wbv", wb_valid, 1);
            check("alu_data", wb_data, alu_vals[i]);
            check("alu_rd", wb_rd, 5 + i);
            check("alu_wbrw", wb_reg_write, 1);
            check("alu_noreq", dmem_req, 0);
        end
        ex_valid = 1'b0;
        tick;
        check("alu_idle_wbv", wb_valid, 0);

        do_store("sb", 32'h00000103, 32'h000000A5, 3'b000, 32'h00000100, 4'b1000, 32'hA5A5A5A5, 3);
        do_store("sh", 32'h00000102, 32'h00001234, 3'b001, 32'h00000100, 4'b1100, 32'h12341234, 0);
        do_store("sw", 32'h00000040, 32'hCAFEBABE, 3'b010, 32'h00000040, 4'b1111, 32'hCAFEBABE, 1);

        do_load("lb",  32'h00000202, 3'b000, 32'h12F45678, 1, 32'h00000200, 32'hFFFFFFF4);
        do_load("lbu", 32'h00000202, 3'b100, 32'h12F45678, 1, 32'h00000200, 32'h000000F4);
        do_load("lh",  32'h00000002, 3'b001, 32'h80010000, 1, 32'h00000000, 32'hFFFF8001);
        do_load("lhu", 32'h00000000, 3'b101, 32'h80019876, 1, 32'h00000000, 32'h00009876);
        do_load("lw",  32'h00000004, 3'b010, 32'hDEADBEEF, 2, 32'h00000004, 32'hDEADBEEF);

        // Illegal load funct3: no access, immediate retire without write.
        issue(32'h00000300, 32'h0, 1'b1, 1'b0, 3'b011, 5'd9, 1'b1);
        check("ill_noreq", dmem_req, 0);
        check("ill_wbv", wb_valid, 1);
        check("ill_wbrw", wb_reg_write, 0);
        tick;
        check("ill_ready", ex_ready, 1);
        // Read and write both high is illegal too.
        issue(32'h00000300, 32'h0, 1'b1, 1'b1, 3'b010, 5'd9, 1'b1);
        check("rw_noreq", dmem_req, 0);
        check("rw_wbrw", wb_reg_write, 0);
        check("rw_wbv", wb_valid, 1);
        // Stray gnt/rvalid while idle do nothing.
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        tick;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check("stray_wbv", wb_valid, 0);
        check("stray_ready", ex_ready, 1);

        // Reset while waiting for load data.
        issue(32'h00000010, 32'h0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw_req", dmem_req, 0);
        check("rstw_ready", ex_ready, 1);
        check("rstw_wbv", wb_valid, 0);
        tick;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h11111111;
        tick;
        dmem_rvalid = 1'b0;
        check("rstw_stray_wbv", wb_valid, 0);
        tick;
        check("rstw_idle_wbv", wb_valid, 0);
        check("rstw_idle_ready", ex_ready, 1);

        // Misaligned word load at 0x6.
        issue(32'h00000006, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_noreq", dmem_req, 0);
        check("mis_wbv", wb_valid, 1);
        check("mis_wbrw", wb_reg_write, 0);
        check("mis_exc", mem_exc, 1);
        check("mis_exc_addr", mem_exc_addr, 32'h00000006);
        tick;
        check("mis_exc_pulse", mem_exc, 0);
        check("mis_ready", ex_ready, 1);
`else
        check("mis_req", dmem_req, 1);
        check("mis_addr", dmem_addr, 32'h00000004);
        check("mis_be", dmem_be, 4'b1111);
        check("mis_exc", mem_exc, 0);
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        tick;
        dmem_rvalid = 1'b0;
        check("mis_wbv", wb_valid, 1);
        check("mis_data", wb_data, 32'hCAFEF00D);
        check("mis_wbrw", wb_reg_write, 1);
        check("mis_exc_addr", mem_exc_addr, 0);
        tick;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
